// File: rtl/mem_io_responder.sv
// mem_io_responder: CPU byte-bus responder with program RAM, UART TX/RX FIFOs, cycle counter and stop latch
module mem_io_responder #(
   parameter int RAM_ADDR_W = 17,
   parameter int FIFO_LOG2  = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] cpu_a,
   input  logic        cpu_wr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        rdy_out,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        program_stop
);
   localparam int DEPTH = 1 << FIFO_LOG2;
   localparam int P = FIFO_LOG2 + 1;
   logic [7:0] mem [0:(1<<RAM_ADDR_W)-1];
   logic [7:0] tx_mem [0:DEPTH-1];
   logic [7:0] rx_mem [0:DEPTH-1];
   logic [P-1:0] tx_wp, tx_rp, rx_wp, rx_rp, tx_cnt, rx_cnt;
   logic [31:0] count;
   logic [31:8] snap;
   logic [7:0] io_rdata;
   logic run, stop_pending, io, is_data, is_cnt, rd, wr, rd_rx, rd_cnt, stop_wr;
   logic tx_push, tx_pop, rx_push, tx_empty, rx_empty;
   logic unused;
   assign unused   = ^cpu_a[31:18];
   assign io       = cpu_a[17:16] == 2'b11;
   assign is_data  = io & (cpu_a[15:0] == 16'h0000);
   assign is_cnt   = io & (cpu_a[15:2] == 14'd1);
   assign rd       = rdy_out & !cpu_wr;
   assign wr       = rdy_out & cpu_wr;
   assign rd_rx    = rd & is_data & !rx_empty;
   assign rd_cnt   = rd & is_cnt & (cpu_a[1:0] == 2'b00);
   assign stop_wr  = wr & is_cnt & (cpu_a[1:0] == 2'b00);
   assign tx_push  = (wr & is_data & (|cpu_wdata)) | stop_wr;
   assign tx_pop   = tx_valid & tx_ready;
   assign rx_push  = rx_valid & rx_ready;
   assign tx_cnt   = tx_wp - tx_rp;
   assign rx_cnt   = rx_wp - rx_rp;
   assign tx_empty = tx_wp == tx_rp;
   assign rx_empty = rx_wp == rx_rp;
   assign tx_valid = !tx_empty;
   assign rx_ready = run & !rx_cnt[FIFO_LOG2];
   assign tx_data  = tx_mem[tx_rp[FIFO_LOG2-1:0]];
   // IO read mux; an empty RX FIFO reads as zero even if a byte lands this cycle
   always_comb
      io_rdata = is_data ? (rx_empty ? 8'h00 : rx_mem[rx_rp[FIFO_LOG2-1:0]]) :
                 !is_cnt ? 8'h00 :
                 cpu_a[1:0] == 2'd0 ? count[7:0] :
                 cpu_a[1:0] == 2'd1 ? snap[15:8] :
                 cpu_a[1:0] == 2'd2 ? snap[23:16] : snap[31:24];
   // RAM write port; contents survive reset
   always_ff @(posedge clk_in)
      if (wr & !io) mem[cpu_a[RAM_ADDR_W-1:0]] <= cpu_wdata;
   // FIFO storage; only the pointers are reset
   always_ff @(posedge clk_in) begin
      if (tx_push) tx_mem[tx_wp[FIFO_LOG2-1:0]] <= is_data ? cpu_wdata : 8'h00;
      if (rx_push) rx_mem[rx_wp[FIFO_LOG2-1:0]] <= rx_data;
   end
   // bus, FIFO pointer, counter and stop-latch state
   always_ff @(posedge clk_in or negedge rst_in)
      if (!rst_in) begin
         run          <= 1'b0;
         rdy_out      <= 1'b0;
         cpu_rdata    <= 8'h00;
         tx_wp        <= '0;
         tx_rp        <= '0;
         rx_wp        <= '0;
         rx_rp        <= '0;
         count        <= 32'd0;
         snap         <= '0;
         stop_pending <= 1'b0;
         program_stop <= 1'b0;
      end else begin
         run          <= 1'b1;
         rdy_out      <= tx_cnt <= P'(DEPTH - 2);
         cpu_rdata    <= !rd ? cpu_rdata : io ? io_rdata : mem[cpu_a[RAM_ADDR_W-1:0]];
         tx_wp        <= tx_wp + P'(tx_push);
         tx_rp        <= tx_rp + P'(tx_pop);
         rx_wp        <= rx_wp + P'(rx_push);
         rx_rp        <= rx_rp + P'(rd_rx);
         count        <= count + 32'd1;
         snap         <= rd_cnt ? count[31:8] : snap;
         stop_pending <= stop_pending | stop_wr;
         program_stop <= program_stop | (stop_pending & tx_empty & !tx_push);
      end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed scoreboard bench for mem_io_responder
module tb_mem_io_responder;
   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic [31:0] cpu_a = '0;
   logic        cpu_wr = 1'b0;
   logic [7:0]  cpu_wdata = '0;
   logic [7:0]  cpu_rdata;
   logic        rdy_out;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b1;
   logic        program_stop;
   int          n_cmp = 0, n_err = 0, n_acc = 0, tx_seen = 0, base;
   logic [31:0] tb_cnt, snapv;
   logic [7:0]  rd_q[$];
   logic [7:0]  tx_q[$];

   mem_io_responder dut (
      .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_wr(cpu_wr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .rdy_out(rdy_out),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .program_stop(program_stop)
   );

   always #5 clk_in = ~clk_in;

   // reference cycle counter
   always @(posedge clk_in or negedge rst_in)
      if (!rst_in) tb_cnt <= 32'd0;
      else tb_cnt <= tb_cnt + 32'd1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // TX monitor: a byte offered while tx_ready is high leaves at the next edge
   always begin
      @(negedge clk_in);
      #2;
      if (rst_in && tx_valid && tx_ready) begin
         check("tx_expected", 32'(tx_q.size() != 0), 32'd1);
         if (tx_q.size() != 0) check("tx_data", tx_data, tx_q.pop_front());
         tx_seen++;
      end
   end

   // one bus request per cycle, driven at a negedge; reads checked one cycle later
   task automatic bus(input logic w, input logic [31:0] a, input logic [7:0] d,
                      input logic chk, input logic [7:0] exp, input string tag);
      logic acc;
      cpu_wr = w;
      cpu_a = a;
      cpu_wdata = d;
      acc = rdy_out;
      if (acc) n_acc++;
      if (acc && w && a[17:0] == 18'h30000 && d != 8'h00) tx_q.push_back(d);
      if (acc && w && a[17:0] == 18'h30004) tx_q.push_back(8'h00);
      if (acc && !w && chk) rd_q.push_back(exp);
      @(negedge clk_in);
      if (chk && !acc) check({tag, "_accepted"}, 32'(acc), 32'd1);
      if (chk && acc) check(tag, cpu_rdata, rd_q.pop_front());
   endtask

   task automatic idle();
      bus(1'b0, 32'h0000_0123, 8'h00, 1'b0, 8'h00, "idle");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk_in);
      check("rst_rdata", cpu_rdata, 8'h00);
      check("rst_rdy", rdy_out, 1'b0);
      check("rst_stop", program_stop, 1'b0);
      check("rst_txv", tx_valid, 1'b0);
      check("rst_rxr", rx_ready, 1'b0);
      rst_in = 1'b1;
      @(negedge clk_in);
      check("rdy_rise", rdy_out, 1'b1);
      check("rxr_rise", rx_ready, 1'b1);
      // RAM write/read, no TX side effect
      bus(1'b1, 32'h0000_0123, 8'hA5, 1'b0, 8'h00, "ram_wr");
      bus(1'b0, 32'h0000_0123, 8'h00, 1'b1, 8'hA5, "ram_rd");
      check("ram_no_tx", tx_valid, 1'b0);
      bus(1'b0, 32'h0003_0008, 8'h00, 1'b1, 8'h00, "io_other");
      // TX writes, 0x00 dropped
      base = tx_seen;
      bus(1'b1, 32'h0003_0000, 8'h41, 1'b0, 8'h00, "tx_wr");
      bus(1'b1, 32'h0003_0000, 8'h00, 1'b0, 8'h00, "tx_wr");
      bus(1'b1, 32'h0003_0000, 8'h42, 1'b0, 8'h00, "tx_wr");
      repeat (5) idle();
      check("tx_count2", tx_seen - base, 2);
      check("tx_q_empty2", tx_q.size(), 0);
      // back-pressure: 20 attempts into a stalled TX FIFO
      tx_ready = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 20; i++) bus(1'b1, 32'h0003_0000, 8'h10 + 8'(i), 1'b0, 8'h00, "bp_wr");
      check("bp_accepted", n_acc, 16);
      check("bp_rdy_low", rdy_out, 1'b0);
      check("bp_txv", tx_valid, 1'b1);
      base = tx_seen;
      tx_ready = 1'b1;
      for (int i = 0; i < 60 && tx_q.size() != 0; i++) idle();
      repeat (2) idle();
      check("bp_drained", tx_seen - base, 16);
      check("bp_rdy_back", rdy_out, 1'b1);
      // counter snapshot after 0x1234 cycles, high address bits ignored
      repeat (32'h1234) idle();
      snapv = tb_cnt;
      bus(1'b0, 32'hFFF3_0004, 8'h00, 1'b1, snapv[7:0], "cnt_b0");
      bus(1'b0, 32'h0003_0005, 8'h00, 1'b1, snapv[15:8], "cnt_b1");
      bus(1'b0, 32'h0003_0006, 8'h00, 1'b1, snapv[23:16], "cnt_b2");
      bus(1'b0, 32'h0003_0007, 8'h00, 1'b1, snapv[31:24], "cnt_b3");
      // RX push racing a pop of the empty FIFO
      rx_valid = 1'b1;
      rx_data = 8'h55;
      bus(1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h00, "rx_race");
      rx_valid = 1'b0;
      bus(1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h55, "rx_next");
      bus(1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h00, "rx_empty");
      // program stop after TX drains
      tx_ready = 1'b0;
      bus(1'b1, 32'h0003_0000, 8'h61, 1'b0, 8'h00, "st_wr");
      bus(1'b1, 32'h0003_0000, 8'h62, 1'b0, 8'h00, "st_wr");
      bus(1'b1, 32'h0003_0000, 8'h63, 1'b0, 8'h00, "st_wr");
      bus(1'b1, 32'h0003_0004, 8'h99, 1'b0, 8'h00, "st_stop");
      idle();
      check("stop_held", program_stop, 1'b0);
      tx_ready = 1'b1;
      for (int i = 0; i < 20 && tx_valid; i++) idle();
      check("stop_drained", tx_valid, 1'b0);
      check("stop_early", program_stop, 1'b0);
      idle();
      check("stop_set", program_stop, 1'b1);
      check("stop_q_empty", tx_q.size(), 0);
      bus(1'b1, 32'h0000_0050, 8'h77, 1'b0, 8'h00, "post_wr");
      bus(1'b0, 32'h0000_0050, 8'h00, 1'b1, 8'h77, "post_rd");
      check("stop_sticky", program_stop, 1'b1);
      // asynchronous reset mid-cycle
      #2 rst_in = 1'b0;
      #1;
      check("arst_stop", program_stop, 1'b0);
      check("arst_rdy", rdy_out, 1'b0);
      check("arst_rdata", cpu_rdata, 8'h00);
      @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);
      bus(1'b0, 32'h0000_0123, 8'h00, 1'b1, 8'hA5, "ram_kept");
      bus(1'b0, 32'h0003_0004, 8'h00, 1'b1, tb_cnt[7:0], "cnt_restart");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
